// File: rtl/spi_master.sv
// Byte-wide SPI master (mode 0, MSB first) with dual SD chip selects,
// programmable clock divisor and a 4-register CPU bus window.
module spi_master #(
  parameter int DIV_RESET = 59
) (
  input  logic       MHZ48,
  input  logic       nRES,
  input  logic       nCS,
  input  logic       RW,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       nSD0,
  output logic       nSD1,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH} stateT;

  stateT      state, stateNext;
  logic       nCsQ;
  logic       strobe, wrStrobe, rdStrobe;
  logic       busy, ovr, start;
  logic       phaseLast, lastBit;
  logic [1:0] ss;
  logic [7:0] div, workDiv, shiftReg, rxData, phaseCnt;
  logic [2:0] bitCnt;
  logic [7:0] shiftIn;

  // The bus select is held low for several cycles; only its falling edge acts.
  assign strobe   = ~nCS & nCsQ;
  assign wrStrobe = strobe & ~RW;
  assign rdStrobe = strobe & RW;

  assign busy      = (state != IDLE);
  assign start     = wrStrobe && (A == 2'd0) && !busy;
  assign phaseLast = (phaseCnt == workDiv);
  assign lastBit   = (bitCnt == 3'd7);
  assign shiftIn   = {shiftReg[6:0], MISO};

  assign nSD0 = ~ss[0];
  assign nSD1 = ~ss[1];

  always_comb begin
    DOUT = 8'hFF;
    case (A)
      2'd0:    DOUT = rxData;
      2'd1:    DOUT = {busy, ovr, 4'b0000, ss};
      2'd2:    DOUT = div;
      default: DOUT = 8'hFF;
    endcase
  end

  always_ff @(posedge MHZ48) begin
    if (!nRES) state <= IDLE;
    else       state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    SCLK      = 1'b0;
    MOSI      = 1'b1;
    case (state)
      IDLE: begin
        if (start) stateNext = LOW;
      end
      LOW: begin
        MOSI = shiftReg[7];
        if (phaseLast) stateNext = HIGH;
      end
      HIGH: begin
        SCLK = 1'b1;
        MOSI = shiftReg[7];
        if (phaseLast) stateNext = lastBit ? IDLE : LOW;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge MHZ48) begin
    if (!nRES) begin
      nCsQ     <= 1'b1;
      ovr      <= 1'b0;
      ss       <= 2'b00;
      div      <= 8'(DIV_RESET);
      workDiv  <= 8'(DIV_RESET);
      shiftReg <= 8'hFF;
      rxData   <= 8'hFF;
      phaseCnt <= 8'd0;
      bitCnt   <= 3'd0;
    end else begin
      nCsQ <= nCS;

      case (state)
        IDLE: begin
          if (start) begin
            shiftReg <= DIN;
            workDiv  <= div;
            phaseCnt <= 8'd0;
            bitCnt   <= 3'd0;
          end
        end
        LOW: begin
          phaseCnt <= phaseLast ? 8'd0 : phaseCnt + 8'd1;
        end
        HIGH: begin
          if (phaseLast) begin
            phaseCnt <= 8'd0;
            shiftReg <= shiftIn;
            if (lastBit) rxData <= shiftIn;
            else         bitCnt <= bitCnt + 3'd1;
          end else begin
            phaseCnt <= phaseCnt + 8'd1;
          end
        end
        default: ;
      endcase

      // Chip selects follow writes at once so software can drop CS mid-byte.
      if (wrStrobe && A == 2'd1) ss <= DIN[1:0];
      if (wrStrobe && A == 2'd2 && !busy) div <= DIN;

      if (wrStrobe && A == 2'd0 && busy) ovr <= 1'b1;
      else if (rdStrobe && A == 2'd1)    ovr <= 1'b0;
    end
  end

endmodule
